reg16_wr_arb: RTL

Write-port arbiter and sequencer for the 16-bit block-size / SDMA-buffer-boundary register. Three requesters (e.g. host register decoder, DMA engine, command sequencer) each present a 12-bit transfer block size and a 3-bit SDMA buffer boundary. The block selects one requester round-robin and drives that requester's data and one-hot write enable (`enb_block0..2`) into the register. It holds the enable until the register returns `ack` or a timeout expires, then reports completion per requester.

---
 rtl/reg16_wr_arb_if.sv | 32 +++
 rtl/reg16_wr_arb.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/reg16_wr_arb_if.sv
// Bus bundle between the block-size/SDMA-boundary register, its three requesters
// and the write-port arbiter.
interface reg16_wr_arb_if;
  logic [2:0]  req;
  logic [35:0] bsize_in;
  logic [8:0]  sdmabuffb_in;
  logic        reg_ack;
  logic        reg_busy;
  logic        enb_block0;
  logic        enb_block1;
  logic        enb_block2;
  logic [11:0] tranfer_bsize_out;
  logic [2:0]  host_sdmabuffb_out;
  logic [2:0]  gnt;
  logic [2:0]  done;
  logic [2:0]  err;
  logic        arb_busy;

  // Arbiter side.
  modport master (
    input  req, bsize_in, sdmabuffb_in, reg_ack, reg_busy,
    output enb_block0, enb_block1, enb_block2, tranfer_bsize_out,
           host_sdmabuffb_out, gnt, done, err, arb_busy
  );

  // Requester/register side.
  modport slave (
    output req, bsize_in, sdmabuffb_in, reg_ack, reg_busy,
    input  enb_block0, enb_block1, enb_block2, tranfer_bsize_out,
           host_sdmabuffb_out, gnt, done, err, arb_busy
  );
endinterface

// File: rtl/reg16_wr_arb.sv
// Round-robin write-port arbiter for the 16-bit block-size / SDMA-boundary register.
// Every output is a flop loaded from the next-state decode.
module reg16_wr_arb #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic            clk,
  input  logic            rst,
  reg16_wr_arb_if.master  bus,
  output logic [1:0]      dbg_state
);

  // Handshake: req is a level held by a requester until it sees done/err for
  // its write; the enable is held from the grant edge until reg_ack is sampled
  // high or TIMEOUT ISSUE cycles elapse, and the outcome pulses during RELEASE.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, next_state;
  logic [1:0]       last;
  logic [1:0]       winner, next_winner;
  logic [CNT_W-1:0] cnt;
  logic             grant;
  logic [2:0]       sel_oh;
  logic [2:0]       nxt_enb, nxt_gnt, nxt_done, nxt_err;
  logic             nxt_busy;

  // Search order is last+1, last+2, last (mod 3).
  function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] l);
    logic [1:0] w;
    w = 2'd0;
    case (l)
      2'd0:    begin if (r[1]) w = 2'd1; else if (r[2]) w = 2'd2; else w = 2'd0; end
      2'd1:    begin if (r[2]) w = 2'd2; else if (r[0]) w = 2'd0; else w = 2'd1; end
      default: begin if (r[0]) w = 2'd0; else if (r[1]) w = 2'd1; else w = 2'd2; end
    endcase
    return w;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] i);
    logic [2:0] o;
    case (i)
      2'd0:    o = 3'b001;
      2'd1:    o = 3'b010;
      2'd2:    o = 3'b100;
      default: o = 3'b000;
    endcase
    return o;
  endfunction

  always_comb begin
    next_state  = state;
    next_winner = winner;
    grant       = 1'b0;
    case (state)
      IDLE: begin
        if ((bus.req != 3'b000) && !bus.reg_busy) begin
          grant       = 1'b1;
          next_winner = pick(bus.req, last);
          next_state  = ISSUE;
        end
      end
      ISSUE: begin
        // reg_ack takes priority over a coincident timeout.
        if (bus.reg_ack || (cnt == TO_LAST)) next_state = RELEASE;
      end
      RELEASE: next_state = IDLE;
      default: next_state = IDLE;
    endcase

    sel_oh   = onehot(next_winner);
    nxt_enb  = (next_state == ISSUE) ? sel_oh : 3'b000;
    nxt_gnt  = ((next_state == ISSUE) || (next_state == RELEASE)) ? sel_oh : 3'b000;
    nxt_done = ((next_state == RELEASE) && bus.reg_ack)  ? sel_oh : 3'b000;
    nxt_err  = ((next_state == RELEASE) && !bus.reg_ack) ? sel_oh : 3'b000;
    nxt_busy = (next_state != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      last   <= 2'd2;
      winner <= 2'd0;
      cnt    <= '0;
    end else begin
      state  <= next_state;
      winner <= next_winner;
      if (grant)                cnt <= '0;
      else if (state == ISSUE)  cnt <= cnt + CNT_W'(1);
      if (state == RELEASE)     last <= winner;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.enb_block0         <= 1'b0;
      bus.enb_block1         <= 1'b0;
      bus.enb_block2         <= 1'b0;
      bus.gnt                <= 3'b000;
      bus.done               <= 3'b000;
      bus.err                <= 3'b000;
      bus.arb_busy           <= 1'b0;
      bus.tranfer_bsize_out  <= 12'h000;
      bus.host_sdmabuffb_out <= 3'b000;
    end else begin
      bus.enb_block0 <= nxt_enb[0];
      bus.enb_block1 <= nxt_enb[1];
      bus.enb_block2 <= nxt_enb[2];
      bus.gnt        <= nxt_gnt;
      bus.done       <= nxt_done;
      bus.err        <= nxt_err;
      bus.arb_busy   <= nxt_busy;
      // Data holds its last granted value until the next grant.
      if (grant) begin
        case (next_winner)
          2'd1: begin
            bus.tranfer_bsize_out  <= bus.bsize_in[23:12];
            bus.host_sdmabuffb_out <= bus.sdmabuffb_in[5:3];
          end
          2'd2: begin
            bus.tranfer_bsize_out  <= bus.bsize_in[35:24];
            bus.host_sdmabuffb_out <= bus.sdmabuffb_in[8:6];
          end
          default: begin
            bus.tranfer_bsize_out  <= bus.bsize_in[11:0];
            bus.host_sdmabuffb_out <= bus.sdmabuffb_in[2:0];
          end
        endcase
      end
    end
  end

  assign dbg_state = state;

endmodule
